uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_tx_arbiter_if.sv | 30 +++
 rtl/uart_tx_arbiter_rr_arb2.sv | 24 ++
 rtl/uart_tx_arbiter.sv | 112 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and default timing for the UART transmit arbiter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    START = 2'd2,
    WAIT  = 2'd3
  } state_t;

  localparam int unsigned FRAME_CYCLES_DEF = 100;
  localparam int unsigned T_BYTE_HOLD_DEF  = 1;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester handshakes and transmitter strobes of the UART transmit arbiter.
interface uart_tx_arbiter_if;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_last;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_last;
  logic       req1_ready;
  logic [7:0] uart_tx_data_Bus;
  logic       Load_XMT_datareg;
  logic       Byte_ready;
  logic       T_byte;
  logic       busy;
  logic       grant;
  logic       frame_done;

  modport master (
    output req0_valid, req0_data, req0_last, req1_valid, req1_data, req1_last,
    input  req0_ready, req1_ready, uart_tx_data_Bus, Load_XMT_datareg,
           Byte_ready, T_byte, busy, grant, frame_done
  );

  modport slave (
    input  req0_valid, req0_data, req0_last, req1_valid, req1_data, req1_last,
    output req0_ready, req1_ready, uart_tx_data_Bus, Load_XMT_datareg,
           Byte_ready, T_byte, busy, grant, frame_done
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_arb2.sv
// Two-way round-robin selector; a lock pins the choice to the current owner.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       locked,
  input  logic       owner,
  input  logic       pointer,
  output logic       sel,
  output logic       any
);

  always_comb begin
    sel = 1'b0;
    any = 1'b0;
    if (locked) begin
      sel = owner;
      any = valid[owner];
    end else begin
      any = |valid;
      if (valid == 2'b11) sel = pointer;
      else                sel = valid[1];
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates two byte requesters onto one UART transmitter and sequences its strobes.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned FRAME_CYCLES = FRAME_CYCLES_DEF,
  parameter int unsigned T_BYTE_HOLD  = T_BYTE_HOLD_DEF
) (
  input logic             clock,
  input logic             reset,
  uart_tx_arbiter_if.slave bus
);

  localparam int unsigned CNT_W  = $clog2(FRAME_CYCLES + 1);
  localparam int unsigned HOLD_W = $clog2(T_BYTE_HOLD + 1);

  if (FRAME_CYCLES == 0 || T_BYTE_HOLD == 0) begin : g_bad_params
    $error("uart_tx_arbiter: FRAME_CYCLES and T_BYTE_HOLD must both be >= 1");
  end

  state_t             state;
  logic [CNT_W-1:0]   frame_cnt;
  logic [HOLD_W-1:0]  hold_cnt;
  logic               locked;
  logic               pointer;
  logic               sel;
  logic               any;
  logic               idle;
  logic               accept;
  logic [7:0]         sel_data;
  logic               sel_last;

  rr_arb2 u_rr_arb2 (
    .valid   ({bus.req1_valid, bus.req0_valid}),
    .locked  (locked),
    .owner   (bus.grant),
    .pointer (pointer),
    .sel     (sel),
    .any     (any)
  );

  assign idle     = (state == IDLE);
  assign accept   = idle && any;
  assign sel_data = sel ? bus.req1_data : bus.req0_data;
  assign sel_last = sel ? bus.req1_last : bus.req0_last;

  // Ready is gated by reset so every output reads 0 while reset is held.
  assign bus.req0_ready = reset && accept && !sel;
  assign bus.req1_ready = reset && accept && sel;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state                <= IDLE;
      frame_cnt            <= '0;
      hold_cnt             <= '0;
      locked               <= 1'b0;
      pointer              <= 1'b0;
      bus.uart_tx_data_Bus <= 8'h00;
      bus.Load_XMT_datareg <= 1'b0;
      bus.Byte_ready       <= 1'b0;
      bus.T_byte           <= 1'b0;
      bus.busy             <= 1'b0;
      bus.grant            <= 1'b0;
      bus.frame_done       <= 1'b0;
    end else begin
      bus.Load_XMT_datareg <= 1'b0;
      bus.frame_done       <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state                <= LOAD;
            bus.uart_tx_data_Bus <= sel_data;
            bus.grant            <= sel;
            bus.Load_XMT_datareg <= 1'b1;
            bus.Byte_ready       <= 1'b1;
            bus.busy             <= 1'b1;
            locked               <= !sel_last;
            if (sel_last) pointer <= !sel;
          end
        end
        LOAD: begin
          state      <= START;
          bus.T_byte <= 1'b1;
          hold_cnt   <= HOLD_W'(1);
        end
        START: begin
          if (hold_cnt == HOLD_W'(T_BYTE_HOLD)) begin
            state          <= WAIT;
            bus.T_byte     <= 1'b0;
            bus.Byte_ready <= 1'b0;
            frame_cnt      <= CNT_W'(1);
            bus.frame_done <= (FRAME_CYCLES == 1);
          end else begin
            hold_cnt <= HOLD_W'(hold_cnt + 1'b1);
          end
        end
        WAIT: begin
          // frame_cnt numbers the WAIT cycles 1..FRAME_CYCLES; frame_done marks the last.
          if (frame_cnt == CNT_W'(FRAME_CYCLES)) begin
            state     <= IDLE;
            bus.busy  <= 1'b0;
            frame_cnt <= '0;
          end else begin
            frame_cnt      <= CNT_W'(frame_cnt + 1'b1);
            bus.frame_done <= (frame_cnt == CNT_W'(FRAME_CYCLES - 1));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (FRAME_CYCLES=100, T_BYTE_HOLD=1).
module tb_uart_tx_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] log_q[$];
  logic [7:0] exp_q[$];
  logic [8:0] q0[$];
  logic [8:0] q1[$];

  uart_tx_arbiter_if bus ();

  uart_tx_arbiter #(.FRAME_CYCLES(100), .T_BYTE_HOLD(1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (bus.Load_XMT_datareg === 1'b1) log_q.push_back(bus.uart_tx_data_Bus);

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({bus.req0_ready, bus.req1_ready, bus.Load_XMT_datareg, bus.Byte_ready,
                bus.T_byte, bus.busy, bus.grant, bus.frame_done, bus.uart_tx_data_Bus});
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req0_valid = 1'b0; bus.req0_data = 8'h00; bus.req0_last = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_data = 8'h00; bus.req1_last = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    repeat (2) cyc();
    log_q.delete(); exp_q.delete(); q0.delete(); q1.delete();
    reset = 1'b1;
    cyc();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < 400) begin
      cyc();
      n++;
    end
    chk("wait_idle_timeout", 32'(bus.busy), 32'd0);
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_count"}, 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      chk({tag, "_byte"}, 32'(log_q[i]), 32'(exp_q[i]));
  endtask

  // Presents queue heads every cycle and pops a byte once its handshake edge has passed.
  task automatic drive_queues(output int both, output int early);
    int n;
    bit a0, a1;
    n = 0; both = 0; early = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 2000) begin
      bus.req0_valid = (q0.size() != 0);
      if (q0.size() != 0) {bus.req0_last, bus.req0_data} = q0[0];
      bus.req1_valid = (q1.size() != 0);
      if (q1.size() != 0) {bus.req1_last, bus.req1_data} = q1[0];
      #1;
      a0 = bus.req0_valid && bus.req0_ready;
      a1 = bus.req1_valid && bus.req1_ready;
      if (bus.req0_ready && bus.req1_ready) both++;
      if (bus.req1_ready && q0.size() != 0) early++;
      cyc();
      if (a0) void'(q0.pop_front());
      if (a1) void'(q1.pop_front());
      n++;
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    chk("drive_timeout", 32'(q0.size() + q1.size()), 32'd0);
  endtask

  task automatic set_req(input bit which, input bit v, input logic [7:0] d);
    if (which) begin bus.req1_valid = v; bus.req1_data = d; bus.req1_last = 1'b1; end
    else       begin bus.req0_valid = v; bus.req0_data = d; bus.req0_last = 1'b1; end
  endtask

  // Single last=1 byte from an idle arbiter; checks every strobe against cycle t.
  task automatic timed_send(input bit which, input logic [7:0] d);
    int fd;
    fd = 0;
    set_req(which, 1'b1, d);
    #1;
    chk("ready_at_t", 32'(which ? bus.req1_ready : bus.req0_ready), 32'd1);
    chk("other_ready_at_t", 32'(which ? bus.req0_ready : bus.req1_ready), 32'd0);
    cyc();
    set_req(which, 1'b0, d);
    #1;
    chk("strobes_t1", 32'({bus.Load_XMT_datareg, bus.Byte_ready, bus.T_byte, bus.busy}), 32'hD);
    chk("bus_t1", 32'(bus.uart_tx_data_Bus), 32'(d));
    chk("grant_t1", 32'(bus.grant), 32'(which));
    cyc();
    chk("strobes_t2", 32'({bus.Load_XMT_datareg, bus.Byte_ready, bus.T_byte}), 32'h3);
    for (int i = 3; i <= 101; i++) begin
      cyc();
      if (bus.frame_done === 1'b1) fd++;
    end
    chk("no_early_frame_done", 32'(fd), 32'd0);
    chk("wait_strobes_low", 32'({bus.Byte_ready, bus.T_byte}), 32'd0);
    cyc();
    chk("frame_done_t102", 32'({bus.frame_done, bus.busy}), 32'h3);
    cyc();
    chk("idle_t103", 32'({bus.frame_done, bus.busy}), 32'd0);
    chk("bus_held_idle", 32'(bus.uart_tx_data_Bus), 32'(d));
    set_req(which, 1'b1, ~d);
    #1;
    chk("ready_again_t103", 32'(which ? bus.req1_ready : bus.req0_ready), 32'd1);
    set_req(which, 1'b0, ~d);
    #1;
  endtask

  initial begin
    int both, early, fd, viol, n;
    bit hit;
    logic [7:0] d;

    // Reset state, with valids asserted to show ready is held low too
    clear_inputs();
    repeat (3) cyc();
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    chk("reset_outputs", outs(), 32'd0);
    clear_inputs();
    reset = 1'b1;
    cyc();

    // Single byte timing
    timed_send(1'b0, 8'h41);
    cyc();
    exp_q = '{8'h41};
    check_log("log_single");

    // Round robin with both requesters
    do_reset();
    q0.push_back({1'b1, 8'h11});
    q1.push_back({1'b1, 8'h22});
    drive_queues(both, early);
    wait_idle();
    q0.push_back({1'b1, 8'h11});
    q1.push_back({1'b1, 8'h22});
    drive_queues(n, early);
    wait_idle();
    chk("rr_one_ready", 32'(both + n), 32'd0);
    exp_q = '{8'h11, 8'h22, 8'h11, 8'h22};
    check_log("log_rr");

    // Packet lock keeps req1 waiting
    do_reset();
    q0.push_back({1'b0, 8'hA1});
    q0.push_back({1'b1, 8'hA2});
    q1.push_back({1'b1, 8'hB1});
    drive_queues(both, early);
    wait_idle();
    chk("lock_req1_early_ready", 32'(early), 32'd0);
    chk("lock_one_ready", 32'(both), 32'd0);
    exp_q = '{8'hA1, 8'hA2, 8'hB1};
    check_log("log_lock");

    // Reset in the middle of a frame
    do_reset();
    set_req(1'b0, 1'b1, 8'h33);
    cyc();
    set_req(1'b0, 1'b0, 8'h33);
    repeat (49) cyc();
    chk("busy_before_abort", 32'(bus.busy), 32'd1);
    bus.req1_valid = 1'b1;
    reset = 1'b0;
    #1;
    chk("abort_outputs", outs(), 32'd0);
    bus.req1_valid = 1'b0;
    repeat (3) cyc();
    reset = 1'b1;
    fd = 0;
    for (int i = 0; i < 110; i++) begin
      cyc();
      if (bus.frame_done === 1'b1 || bus.busy === 1'b1) fd++;
    end
    chk("abort_no_frame_done", 32'(fd), 32'd0);
    timed_send(1'b1, 8'h5A);
    exp_q = '{8'h33, 8'h5A};
    check_log("log_abort");

    // Data changing during busy: only the accept-edge value is sent
    do_reset();
    d = 8'hC0;
    set_req(1'b1, 1'b1, d);
    #1;
    chk("chg_first_ready", 32'(bus.req1_ready), 32'd1);
    cyc();
    n = 0;
    hit = 1'b0;
    do begin
      n++;
      d = d + 8'd1;
      bus.req1_data = d;
      #1;
      if (n == 50) chk("chg_bus_mid", 32'(bus.uart_tx_data_Bus), 32'hC0);
      hit = bus.req1_ready;
      if (!hit) cyc();
    end while (!hit && n < 300);
    chk("chg_accept_value", 32'(d), 32'h27);
    cyc();
    bus.req1_valid = 1'b0;
    wait_idle();
    chk("chg_bus_final", 32'(bus.uart_tx_data_Bus), 32'h27);
    exp_q = '{8'hC0, 8'h27};
    check_log("log_chg");

    // Locked owner idle: the other requester is starved
    do_reset();
    q0.push_back({1'b0, 8'h77});
    drive_queues(both, early);
    wait_idle();
    bus.req1_valid = 1'b1;
    bus.req1_data  = 8'h99;
    bus.req1_last  = 1'b1;
    viol = 0;
    for (int i = 0; i < 300; i++) begin
      cyc();
      if (bus.busy !== 1'b0 || bus.grant !== 1'b0 || bus.req1_ready !== 1'b0 ||
          bus.Load_XMT_datareg !== 1'b0) viol++;
    end
    chk("starve_violations", 32'(viol), 32'd0);
    q0.push_back({1'b1, 8'h88});
    q1.push_back({1'b1, 8'h99});
    drive_queues(both, early);
    wait_idle();
    chk("starve_grant_after", 32'(bus.grant), 32'd1);
    exp_q = '{8'h77, 8'h88, 8'h99};
    check_log("log_starve");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
